// File: rtl/fft_loader_pkg.sv
// Constants shared between the FFT loader and the FFT core: frame size,
// float layout of the complex memory word, and the loader FSM states.
package fft_loader_pkg;

  localparam int LOGN     = 12;
  localparam int N        = 1 << LOGN;
  localparam int SW       = 16;
  localparam int FW       = 32;
  localparam int CW       = 2 * FW;
  localparam int RE_MSB   = CW - 1;
  localparam int RE_LSB   = FW;
  localparam int IM_MSB   = FW - 1;
  localparam int IM_LSB   = 0;
  localparam int EXP_W    = 8;
  localparam int EXP_BIAS = 127;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    DRAIN = 2'd1,
    KICK  = 2'd2,
    WAIT  = 2'd3
  } state_t;

endpackage

// File: rtl/fft_loader_if.sv
// Sample stream and FFT host-port signals of the loader, bundled as one port.
interface fft_loader_if;
  import fft_loader_pkg::*;

  logic            s_valid;
  logic [SW-1:0]   s_data;
  logic            s_ready;
  logic            fft_we;
  logic            fft_rev;
  logic [LOGN-1:0] fft_addr;
  logic [CW-1:0]   fft_din;
  logic            fft_sig;
  logic            fft_done;
  logic            frame_busy;

  modport master (
    output s_valid, s_data, fft_done,
    input  s_ready, fft_we, fft_rev, fft_addr, fft_din, fft_sig, frame_busy
  );

  modport slave (
    input  s_valid, s_data, fft_done,
    output s_ready, fft_we, fft_rev, fft_addr, fft_din, fft_sig, frame_busy
  );

endinterface

// File: rtl/fft_loader_int_to_float.sv
// Two-stage exact conversion of a signed SW-bit integer to single precision;
// the sample index travels alongside so the write address stays aligned.
module fft_loader_int_to_float
  import fft_loader_pkg::*;
#(
  parameter int SW = 16,
  parameter int FW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            smp_valid,
  input  logic [SW-1:0]   smp_data,
  input  logic [LOGN-1:0] smp_idx,
  output logic            flt_valid,
  output logic [FW-1:0]   flt_word,
  output logic [LOGN-1:0] flt_idx
);

  localparam int MW = FW - 1 - EXP_W;
  localparam int PW = $clog2(SW + 1);

  function automatic logic [PW-1:0] lead_one(input logic [SW:0] v);
    logic [PW-1:0] pos;
    pos = '0;
    for (int i = 0; i <= SW; i++) begin
      if (v[i]) begin
        pos = PW'(i);
      end
    end
    return pos;
  endfunction

  logic [SW:0]      ext_s, mag_s, norm_s;
  logic [SW+MW-1:0] mant_ext_s;
  logic [EXP_W-1:0] exp_s;
  logic [FW-1:0]    word_s;
  logic             sign_r, v1_r;
  logic [SW:0]      mag_r;
  logic [PW-1:0]    pos_r;
  logic [LOGN-1:0]  idx1_r;

  // Magnitude is one bit wider than the input so -2^(SW-1) stays positive
  assign ext_s = {smp_data[SW-1], smp_data};
  assign mag_s = smp_data[SW-1] ? (~ext_s + (SW+1)'(1)) : ext_s;

  // Stage 1: sign, magnitude and leading-one position
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_r   <= 1'b0;
      sign_r <= 1'b0;
      mag_r  <= '0;
      pos_r  <= '0;
      idx1_r <= '0;
    end else begin
      v1_r <= smp_valid;
      if (smp_valid) begin
        sign_r <= smp_data[SW-1];
        mag_r  <= mag_s;
        pos_r  <= lead_one(mag_s);
        idx1_r <= smp_idx;
      end
    end
  end

  // Normalise so the leading one sits at bit SW, then drop it as the hidden bit
  always_comb begin
    norm_s     = mag_r << (PW'(SW) - pos_r);
    mant_ext_s = {norm_s[SW-1:0], {MW{1'b0}}};
    exp_s      = EXP_W'(EXP_BIAS) + EXP_W'(pos_r);
    word_s     = (mag_r == '0) ? '0 : {sign_r, exp_s, mant_ext_s[SW+MW-1 -: MW]};
  end

  // Stage 2: packed float and its index
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flt_valid <= 1'b0;
      flt_word  <= '0;
      flt_idx   <= '0;
    end else begin
      flt_valid <= v1_r;
      if (v1_r) begin
        flt_word <= word_s;
        flt_idx  <= idx1_r;
      end
    end
  end

endmodule

// File: rtl/fft_loader.sv
// FFT front-end: fills one frame of converted samples into FFT memory
// (bit-reversed by the core), kicks the core and waits for fft_done.
module fft_loader
  import fft_loader_pkg::*;
(
  input logic         clk,
  input logic         rst,
  fft_loader_if.slave bus
);

  localparam logic [LOGN-1:0] IDX_LAST = '1;

  state_t          state_r, state_s;
  logic [LOGN-1:0] idx_r;
  logic            drain_r, ready_r, sig_r, busy_r;
  logic            accept_s;
  logic            flt_valid_s;
  logic [FW-1:0]   flt_word_s;
  logic [LOGN-1:0] flt_idx_s;
  logic [CW-1:0]   din_s;

  assign accept_s = bus.s_valid & ready_r;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= FILL;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; fft_done outside WAIT is deliberately ignored
  always_comb begin
    state_s = state_r;
    case (state_r)
      FILL:    state_s = (accept_s && idx_r == IDX_LAST) ? DRAIN : FILL;
      DRAIN:   state_s = drain_r ? KICK : DRAIN;
      KICK:    state_s = WAIT;
      WAIT:    state_s = bus.fft_done ? FILL : WAIT;
      default: state_s = FILL;
    endcase
  end

  // Index counter, drain timer and registered handshake/control outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_r   <= '0;
      drain_r <= 1'b0;
      ready_r <= 1'b0;
      sig_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      if (accept_s) begin
        idx_r <= idx_r + LOGN'(1);
      end
      drain_r <= (state_r == DRAIN) ? ~drain_r : 1'b0;
      ready_r <= (state_s == FILL);
      sig_r   <= (state_s == KICK);
      if (accept_s) begin
        busy_r <= 1'b1;
      end else if (state_r == WAIT && bus.fft_done) begin
        busy_r <= 1'b0;
      end
    end
  end

  fft_loader_int_to_float #(.SW(SW), .FW(FW)) u_cvt (
    .clk       (clk),
    .rst       (rst),
    .smp_valid (accept_s),
    .smp_data  (bus.s_data),
    .smp_idx   (idx_r),
    .flt_valid (flt_valid_s),
    .flt_word  (flt_word_s),
    .flt_idx   (flt_idx_s)
  );

  // Complex word: converted real part, imaginary part always zero
  always_comb begin
    din_s                 = '0;
    din_s[RE_MSB:RE_LSB]  = flt_word_s;
    din_s[IM_MSB:IM_LSB]  = '0;
  end

  assign bus.s_ready    = ready_r;
  assign bus.fft_we     = flt_valid_s;
  assign bus.fft_rev    = flt_valid_s;
  assign bus.fft_addr   = flt_idx_s;
  assign bus.fft_din    = din_s;
  assign bus.fft_sig    = sig_r;
  assign bus.frame_busy = busy_r;

endmodule
